dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and byte-serializing controller for the single-port, byte-wide, 32-byte data memory. It shares the memory between requester A (processor load/store path) and requester B (debug/loader port). It grants one requester at a time and splits each 32-bit word access into four big-endian byte accesses. It returns a one-cycle acknowledge, plus assembled read data for reads.

## Interface
- Parameter `ADDR_W`, default 5: byte address width. Memory depth is 2^ADDR_W bytes.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `a_req`  input  1  requester A access request; held high until `a_ack`.
- `a_we`  input  1  A: 1 = write, 0 = read.
- `a_addr`  input  ADDR_W  A: byte address of the word's most-significant byte.
- `a_wdata`  input  32  A: write data.
- `a_ack`  output  1  A: one-cycle completion pulse.
- `a_rdata`  output  32  A: read data; valid with `a_ack`, held until A's next read completes.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: same as the A ports, for requester B.
- `mem_en`  output  1  byte-access strobe.
- `mem_we`  output  1  byte write enable; only meaningful while `mem_en` is high.
- `mem_addr`  output  ADDR_W  byte address.
- `mem_wdata`  output  8  byte write data.
- `mem_rdata`  input  8  byte read data; synchronous, valid in the cycle after `mem_en` with `mem_we`=0.
- `busy`  output  1  high in every state other than IDLE.
- `grant_b`  output  1  current or most recent grant: 0 = A, 1 = B.

## Operation
- FSM states: IDLE, XFER, CAPT, ACK.
- **IDLE**
  - If any `req` is high: arbitrate, then latch the winner's `we`, `addr` and `wdata`.
  - Set byte counter `cnt`=0 and go to XFER.
- **XFER**
  - Drive `mem_en`=1, `mem_we`=latched `we`, `mem_addr`=latched `addr`+`cnt`.
  - Addition is modulo 2^ADDR_W, so addresses wrap; misaligned addresses are legal.
  - `mem_wdata` = byte `3-cnt` of the latched data: `cnt`0 carries bits [31:24], `cnt`3 carries bits [7:0].
  - Reads: `mem_rdata` seen during XFER with `cnt`=k (k≥1) is byte k-1; capture it into the matching byte lane of the winner's `rdata` shadow register.
  - Increment `cnt` each cycle.
  - After `cnt`=3: a read goes to CAPT; a write goes to ACK.
- **CAPT** (reads only): `mem_en`=0; capture byte 3 into bits [7:0]; go to ACK.
- **ACK**
  - Assert the winner's `ack` for exactly one cycle.
  - On a read, the winner's `rdata` updates with the shadow value at entry to ACK.
  - Go to IDLE.
- **Arbitration**
  - Round-robin: if both requests are high in IDLE, grant the requester not granted last.
  - After reset the "last grant" is B, so A wins the first conflict.
  - A single request is always granted.
- **Requester rule**: deassert `req` in the cycle after `ack`. A `req` still high in IDLE is a new request.
  - The block latches all request fields at grant, so later changes to `addr`, `we` or `wdata` during the transaction are ignored.
- The loser's `rdata` is never modified.

## Timing
- **Reset values**: all outputs 0, `rdata` registers 0, state IDLE, last grant = B.
- **Read latency**
  - `req` sampled at edge E0.
  - Byte accesses in the cycles after E0..E3.
  - Byte 3 captured at E5.
  - `ack` high between E5 and E6.
  - Total 6 cycles per read.
- **Write latency**: `ack` high between E4 and E5. Total 5 cycles per write.
- **Back-to-back**: the next arbitration is in the IDLE cycle after ACK. There is no idle gap beyond the IDLE state.
- **Reset mid-transaction**
  - Immediate return to reset values; no `ack` is issued.
  - Bytes already written stay in memory, so a partial word is possible.
- `busy` and `grant_b` are registered with the state and change only on clock edges.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined: fixed priority, A always wins a conflict, and the last-grant register is not implemented.
- `DMEM_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.

## Test plan
- **Reset**: `rst_n`=0 mid-XFER of a write to `addr` 4. All outputs go to 0 asynchronously, no `ack` follows, and after release `busy`=0.
- **A write then read**: A writes 0x12345678 at `addr` 8. Bytes 8..11 = 12, 34, 56, 78 and `a_ack` arrives 5 cycles after grant. A then reads `addr` 8: `a_rdata`=0x12345678 with `a_ack` 6 cycles after grant.
- **Wrap-around**: B writes 0xAABBCCDD at `addr` 30. Bytes land at 30, 31, 0, 1 = AA, BB, CC, DD. B reading `addr` 30 returns 0xAABBCCDD.
- **Simultaneous requests (round-robin)**: `a_req` and `b_req` both high continuously for 4 transactions. Grants alternate A, B, A, B with no lost request, and each `ack` appears on the correct port only. With `DMEM_ARB_FIXED_PRIO_EN` defined and A re-requesting immediately, A is granted every time and B waits.
- **Read isolation**: B reads `addr` 0 (0x01020304) while A holds a previous `a_rdata`=0xDEADBEEF. `a_rdata` stays 0xDEADBEEF and `b_rdata`=0x01020304.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, byte-wide data memory between requester A
// (load/store path) and requester B (debug/loader). Each granted 32-bit access is
// serialized into four big-endian byte accesses at addr, addr+1, addr+2, addr+3
// (modulo memory depth). The winner gets a one-cycle ack, plus assembled data on reads.
//
// Build option: DMEM_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, A wins every conflict, no grant history kept.
//   undefined -> round-robin; after reset B counts as last granted, so A wins first.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  // Requester A
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_ack,
  output logic [31:0]       a_rdata,
  // Requester B
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_ack,
  output logic [31:0]       b_rdata,
  // Byte memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  // Status
  output logic              busy,
  output logic              grant_b
);

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StCapt,
    StAck
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  // Upper three bytes of a read; the last byte goes straight into the rdata register.
  logic [23:0]       shadow_q, shadow_d;
  logic [31:0]       a_rdata_q, a_rdata_d;
  logic [31:0]       b_rdata_q, b_rdata_d;
  logic              grant_b_q, grant_b_d;
  logic              win_b;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // A wins any conflict; B is granted only when it requests alone.
  always_comb begin
    win_b = b_req & ~a_req;
  end
`else
  logic last_b_q, last_b_d;

  // Round-robin: on a conflict the requester not granted last wins.
  always_comb begin
    win_b    = b_req & (~a_req | ~last_b_q);
    last_b_d = last_b_q;
    if (state_q == StIdle && (a_req || b_req)) begin
      last_b_d = win_b;
    end
  end

  // Grant history; resets to B so that A wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`endif

  // Next-state logic: arbitration, request latching, byte sequencing and read assembly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    shadow_d  = shadow_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    grant_b_d = grant_b_q;

    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          grant_b_d = win_b;
          we_d      = win_b ? b_we    : a_we;
          addr_d    = win_b ? b_addr  : a_addr;
          wdata_d   = win_b ? b_wdata : a_wdata;
          cnt_d     = 2'd0;
          state_d   = StXfer;
        end
      end

      StXfer: begin
        // Read data lags the access by one cycle: at cnt=k we see byte k-1.
        if (!we_q) begin
          unique case (cnt_q)
            2'd1:    shadow_d[23:16] = mem_rdata;
            2'd2:    shadow_d[15:8]  = mem_rdata;
            2'd3:    shadow_d[7:0]   = mem_rdata;
            default: ;
          endcase
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = we_q ? StAck : StCapt;
        end
      end

      StCapt: begin
        // Last byte arrives now; publish the full word to the winner only.
        if (grant_b_q) begin
          b_rdata_d = {shadow_q, mem_rdata};
        end else begin
          a_rdata_d = {shadow_q, mem_rdata};
        end
        state_d = StAck;
      end

      StAck: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      shadow_q  <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      grant_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      shadow_q  <= shadow_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      grant_b_q <= grant_b_d;
    end
  end

  // Memory strobes: active only in XFER, big-endian byte order, address wraps.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    if (state_q == StXfer) begin
      mem_en   = 1'b1;
      mem_we   = we_q;
      mem_addr = addr_q + ADDR_W'(cnt_q);
      unique case (cnt_q)
        2'd0:    mem_wdata = wdata_q[31:24];
        2'd1:    mem_wdata = wdata_q[23:16];
        2'd2:    mem_wdata = wdata_q[15:8];
        default: mem_wdata = wdata_q[7:0];
      endcase
    end
  end

  // Status and acknowledge are decoded from registered state only.
  always_comb begin
    a_ack   = (state_q == StAck) && !grant_b_q;
    b_ack   = (state_q == StAck) && grant_b_q;
    busy    = (state_q != StIdle);
    grant_b = grant_b_q;
    a_rdata = a_rdata_q;
    b_rdata = b_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter. A word-level reference
// model predicts grant order and read data when stimulus is issued; a negedge monitor
// pops and checks each acknowledge independently of the driver.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [31:0]   a_wdata = '0;
  logic          a_ack;
  logic [31:0]   a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [31:0]   b_wdata = '0;
  logic          b_ack;
  logic [31:0]   b_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'h00;
  logic          busy, grant_b;

  dmem_arbiter #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .grant_b   (grant_b)
  );

  always #5 clk = ~clk;

  // Byte-wide synchronous memory attached to the DUT.
  logic [7:0] mem [DEPTH] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    bit            port_b;
    bit            we;
    logic [AW-1:0] addr;
    logic [31:0]   data;   // write data, or expected read data once in the scoreboard
  } cmd_t;

  cmd_t sb[$];
  cmd_t qa[$];
  cmd_t qb[$];

  int tests = 0;
  int fails = 0;

  // Reference model state: word-level view of memory plus grant history.
  logic [7:0] ref_mem [DEPTH] = '{default: 8'h00};
  bit         last_b = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w = {w[23:0], ref_mem[(int'(a) + i) % DEPTH]};
    return w;
  endfunction

  task automatic ref_write(input logic [AW-1:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) ref_mem[(int'(a) + i) % DEPTH] = d[8*(3-i) +: 8];
  endtask

  function automatic logic [31:0] dut_mem_word(input logic [AW-1:0] a);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w = {w[23:0], mem[(int'(a) + i) % DEPTH]};
    return w;
  endfunction

  function automatic cmd_t mk(input bit we, input int addr, input logic [31:0] d);
    cmd_t c;
    c.port_b = 1'b0;
    c.we     = we;
    c.addr   = AW'(addr);
    c.data   = d;
    return c;
  endfunction

  // Monitor: every acknowledge pops one expected response.
  int          cyc = 0;
  int          start = 0;
  bit          busy_prev = 1'b0;
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;

  always @(negedge clk) begin
    cmd_t e;
    cyc++;
    if (!rst_n) begin
      busy_prev = 1'b0;
      exp_a     = '0;
      exp_b     = '0;
    end else begin
      if (busy && !busy_prev) start = cyc;
      busy_prev = busy;
      if (a_ack || b_ack) begin
        check("ack_both", 32'(a_ack & b_ack), 32'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b with nothing pending",
                   a_ack, b_ack);
        end else begin
          e = sb.pop_front();
          check("ack_port", 32'(b_ack), 32'(e.port_b));
          check("grant_b", 32'(grant_b), 32'(e.port_b));
          check("latency", 32'(cyc - start), e.we ? 32'd4 : 32'd5);
          if (!e.we) begin
            if (e.port_b) exp_b = e.data;
            else          exp_a = e.data;
          end
          check("a_rdata", a_rdata, exp_a);
          check("b_rdata", b_rdata, exp_b);
          if (e.we) check("mem_word", dut_mem_word(e.addr), e.data);
        end
      end
    end
  end

  task automatic load_a(input cmd_t c);
    a_we = c.we; a_addr = c.addr; a_wdata = c.data;
  endtask

  task automatic load_b(input cmd_t c);
    b_we = c.we; b_addr = c.addr; b_wdata = c.data;
  endtask

  // Predict grant order from the arbitration rule, fill the scoreboard, then drive
  // both requesters; each keeps req high while it still has commands queued.
  task automatic run();
    cmd_t ta[$];
    cmd_t tb_q[$];
    cmd_t c;
    bit   pick_b, ack_a, ack_b;
    int   budget;
    ta   = qa;
    tb_q = qb;
    while (ta.size() > 0 || tb_q.size() > 0) begin
      if (ta.size() > 0 && tb_q.size() > 0) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        pick_b = 1'b0;
`else
        pick_b = !last_b;
`endif
      end else begin
        pick_b = (tb_q.size() > 0);
      end
      c = pick_b ? tb_q.pop_front() : ta.pop_front();
      c.port_b = pick_b;
      if (c.we) ref_write(c.addr, c.data);
      else      c.data = ref_read(c.addr);
      sb.push_back(c);
      last_b = pick_b;
    end

    @(negedge clk);
    if (qa.size() > 0) begin load_a(qa[0]); a_req = 1'b1; end
    if (qb.size() > 0) begin load_b(qb[0]); b_req = 1'b1; end
    budget = 0;
    while ((qa.size() > 0 || qb.size() > 0) && budget < 400) begin
      budget++;
      @(negedge clk);
      ack_a = a_ack;
      ack_b = b_ack;
      @(posedge clk);
      #1;
      if (ack_a) begin
        void'(qa.pop_front());
        if (qa.size() > 0) load_a(qa[0]);
        else               a_req = 1'b0;
      end
      if (ack_b) begin
        void'(qb.pop_front());
        if (qb.size() > 0) load_b(qb[0]);
        else               b_req = 1'b0;
      end
      // Disturb the winner's fields mid-transaction; they were latched at grant.
      if (busy && !ack_a && !ack_b) begin
        if (grant_b) begin
          b_we = 1'($urandom_range(0, 1)); b_addr = AW'($urandom); b_wdata = $urandom;
        end else begin
          a_we = 1'($urandom_range(0, 1)); a_addr = AW'($urandom); a_wdata = $urandom;
        end
      end
    end
    if (qa.size() > 0 || qb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d A and %0d B commands never acknowledged",
               qa.size(), qb.size());
      qa.delete();
      qb.delete();
      a_req = 1'b0;
      b_req = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_acks"}, {30'd0, a_ack, b_ack}, 32'd0);
    check({tag, "_a_rdata"}, a_rdata, 32'd0);
    check({tag, "_b_rdata"}, b_rdata, 32'd0);
    check({tag, "_mem"}, {mem_en, mem_we, 17'd0, mem_addr, mem_wdata}, 32'd0);
    check({tag, "_status"}, {30'd0, busy, grant_b}, 32'd0);
  endtask

  initial begin
    int na, nb;
    // Reset state.
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a write to addr 4: first byte already written.
    a_we = 1'b1; a_addr = AW'(4); a_wdata = 32'h11223344; a_req = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    a_req = 1'b0;
    ref_mem[4] = 8'h11;
    last_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_idle", 32'(busy), 32'd0);
    check("midrst_byte4", 32'(mem[4]), 32'h11);
    check("midrst_byte5", 32'(mem[5]), 32'(ref_mem[5]));

    // A write then read at 8; partial word at 4.
    qa.push_back(mk(1, 8, 32'h12345678)); run();
    qa.push_back(mk(0, 8, 0));            run();
    qa.push_back(mk(0, 4, 0));            run();
    // Wrap-around through B.
    qb.push_back(mk(1, 30, 32'hAABBCCDD)); run();
    qb.push_back(mk(0, 30, 0));            run();
    // Read isolation.
    qb.push_back(mk(1, 0, 32'h01020304));
    qa.push_back(mk(1, 16, 32'hDEADBEEF)); run();
    qa.push_back(mk(0, 16, 0));            run();
    qb.push_back(mk(0, 0, 0));             run();
    // Continuous contention for four transactions.
    qa.push_back(mk(1, 12, 32'hCAFEF00D)); qa.push_back(mk(0, 0, 0));
    qb.push_back(mk(1, 20, 32'h5A5AA5A5)); qb.push_back(mk(0, 12, 0));
    run();

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      if (na + nb == 0) na = 1;
      for (int i = 0; i < na; i++)
        qa.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom));
      for (int i = 0; i < nb; i++)
        qb.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom));
      run();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
